// File: rtl/multicycle_main_decoder_if.sv
// Instruction-field and control-strobe bundle between the instruction register
// side (master) and the multicycle main decoder (slave).
interface multicycle_main_decoder_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite;
    logic       NextPC;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ALUControl;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic [3:0] State;

    modport master (
        output Op, Funct, Rd,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
               ImmSrc, RegSrc, FlagW, PCS, RegW, MemW, State
    );

    modport slave (
        input  Op, Funct, Rd,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
               ImmSrc, RegSrc, FlagW, PCS, RegW, MemW, State
    );
endinterface

// File: rtl/multicycle_main_decoder.sv
// Multicycle ARM-subset control FSM and instruction decoder (Moore outputs).
// Optional macro CMP_NOWRITE_EN: cmd 1010 decodes as a flag-only SUB (CMP).
module multicycle_main_decoder #(
    parameter int unsigned PC_IDX = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_main_decoder_if.slave    dec
);
    localparam int unsigned RD_W = 4;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cmd_c;
    logic       s_bit_c;
    logic [1:0] alu_cmd_c;
    logic       flag_cv_c;
    logic       cmp_nowrite_c;
    logic       branch_c;
    logic       regw_c;

    assign cmd_c   = dec.Funct[4:1];
    assign s_bit_c = dec.Funct[0];

    // cmd -> ALU operation; unsupported commands fall back to ADD
    always_comb begin
        alu_cmd_c     = 2'b00;
        flag_cv_c     = 1'b0;
        cmp_nowrite_c = 1'b0;
        case (cmd_c)
            4'b0100: begin alu_cmd_c = 2'b00; flag_cv_c = 1'b1; end
            4'b0010: begin alu_cmd_c = 2'b01; flag_cv_c = 1'b1; end
            4'b0000: alu_cmd_c = 2'b10;
            4'b1100: alu_cmd_c = 2'b11;
`ifdef CMP_NOWRITE_EN
            4'b1010: begin
                alu_cmd_c     = 2'b01;
                flag_cv_c     = 1'b1;
                cmp_nowrite_c = s_bit_c;
            end
`endif
            default: alu_cmd_c = 2'b00;
        endcase
    end

    // next-state: unused encodings recover to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (dec.Op)
                    2'b00:   state_d = dec.Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = s_bit_c ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // per-state output decode; reset masks everything so an aborted
    // instruction can never write memory or registers
    always_comb begin
        dec.IRWrite    = 1'b0;
        dec.NextPC     = 1'b0;
        dec.AdrSrc     = 1'b0;
        dec.ALUSrcA    = 2'b00;
        dec.ALUSrcB    = 2'b00;
        dec.ResultSrc  = 2'b00;
        dec.ALUControl = 2'b00;
        dec.FlagW      = 2'b00;
        dec.MemW       = 1'b0;
        dec.ImmSrc     = dec.Op;
        dec.RegSrc     = {dec.Op == 2'b01, dec.Op == 2'b10};
        dec.State      = state_q;
        branch_c       = 1'b0;
        regw_c         = 1'b0;

        case (state_q)
            S_FETCH: begin
                dec.IRWrite   = 1'b1;
                dec.NextPC    = 1'b1;
                dec.ALUSrcA   = 2'b01;
                dec.ALUSrcB   = 2'b10;
                dec.ResultSrc = 2'b10;
            end
            S_DECODE: begin
                dec.ALUSrcA   = 2'b01;
                dec.ALUSrcB   = 2'b10;
                dec.ResultSrc = 2'b10;
            end
            S_MEMADR:  dec.ALUSrcB = 2'b01;
            S_MEMREAD: dec.AdrSrc  = 1'b1;
            S_MEMWB: begin
                dec.ResultSrc = 2'b01;
                regw_c        = 1'b1;
            end
            S_MEMWRITE: begin
                dec.AdrSrc = 1'b1;
                dec.MemW   = 1'b1;
            end
            S_EXECUTER, S_EXECUTEI: begin
                dec.ALUSrcB    = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
                dec.ALUControl = alu_cmd_c;
                dec.FlagW      = s_bit_c ? {1'b1, flag_cv_c} : 2'b00;
            end
            S_ALUWB: regw_c = ~cmp_nowrite_c;
            S_BRANCH: begin
                dec.ALUSrcA   = 2'b10;
                dec.ALUSrcB   = 2'b01;
                dec.ResultSrc = 2'b10;
                branch_c      = 1'b1;
            end
            default: ;
        endcase

        dec.RegW = regw_c;
        dec.PCS  = branch_c | (regw_c & (dec.Rd == RD_W'(PC_IDX)));

        if (reset) begin
            dec.IRWrite    = 1'b0;
            dec.NextPC     = 1'b0;
            dec.AdrSrc     = 1'b0;
            dec.ALUSrcA    = 2'b00;
            dec.ALUSrcB    = 2'b00;
            dec.ResultSrc  = 2'b00;
            dec.ALUControl = 2'b00;
            dec.ImmSrc     = 2'b00;
            dec.RegSrc     = 2'b00;
            dec.FlagW      = 2'b00;
            dec.PCS        = 1'b0;
            dec.RegW       = 1'b0;
            dec.MemW       = 1'b0;
            dec.State      = S_FETCH;
        end
    end
endmodule

// File: tb/tb_multicycle_main_decoder.sv
// Scoreboard bench for multicycle_main_decoder: directed instructions push
// hand-computed per-cycle expectations; a negedge monitor pops and compares.
module tb_multicycle_main_decoder;
    typedef struct packed {
        logic [3:0] st;
        logic       irw, npc, adr;
        logic [1:0] asa, asb, rs, alu, imm, rsrc, flw;
        logic       pcs, regw, memw;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t  exp_q[$];
    string nm_q[$];

    multicycle_main_decoder_if bus ();

    multicycle_main_decoder #(.PC_IDX(15)) dut (
        .clk   (clk),
        .reset (reset),
        .dec   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] st, input logic irw, input logic npc,
                                input logic adr, input logic [1:0] asa, input logic [1:0] asb,
                                input logic [1:0] rs, input logic [1:0] alu, input logic [1:0] flw,
                                input logic pcs, input logic regw, input logic memw);
        exp_t e;
        e = '0;
        e.st = st; e.irw = irw; e.npc = npc; e.adr = adr;
        e.asa = asa; e.asb = asb; e.rs = rs; e.alu = alu; e.flw = flw;
        e.pcs = pcs; e.regw = regw; e.memw = memw;
        return e;
    endfunction

    // one clock of stimulus plus the expectation for that cycle
    task automatic cyc(input string nm, input logic rst, input logic [1:0] op,
                       input logic [5:0] fn, input logic [3:0] rd, input exp_t e);
        exp_t x;
        @(posedge clk);
        #1;
        reset     = rst;
        bus.Op    = op;
        bus.Funct = fn;
        bus.Rd    = rd;
        x         = e;
        x.imm     = rst ? 2'b00 : op;
        x.rsrc    = rst ? 2'b00 : {op == 2'b01, op == 2'b10};
        exp_q.push_back(x);
        nm_q.push_back(nm);
    endtask

    task automatic instr(input string nm, input logic [1:0] op, input logic [5:0] fn,
                         input logic [3:0] rd, input exp_t seq[$]);
        foreach (seq[i]) cyc($sformatf("%s.c%0d", nm, i), 1'b0, op, fn, rd, seq[i]);
    endtask

    // monitor: every cycle the decoder presents a full control word
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string n;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            a = '{st: bus.State, irw: bus.IRWrite, npc: bus.NextPC, adr: bus.AdrSrc,
                  asa: bus.ALUSrcA, asb: bus.ALUSrcB, rs: bus.ResultSrc, alu: bus.ALUControl,
                  imm: bus.ImmSrc, rsrc: bus.RegSrc, flw: bus.FlagW,
                  pcs: bus.PCS, regw: bus.RegW, memw: bus.MemW};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h (st=%0d regw=%b memw=%b pcs=%b flw=%b alu=%b)",
                         n, a, e, a.st, a.regw, a.memw, a.pcs, a.flw, a.alu);
            end
        end
    end

    initial begin
        exp_t z, fe, de, ma, mr, mwb, mwb_pc, mw, wb, wb_pc, br;
        z      = mk(4'd0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        fe     = mk(4'd0, 1, 1, 0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0);
        de     = mk(4'd1, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0);
        ma     = mk(4'd2, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        mr     = mk(4'd3, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        mwb    = mk(4'd4, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 0, 1, 0);
        mwb_pc = mk(4'd4, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1, 1, 0);
        mw     = mk(4'd5, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
        wb     = mk(4'd8, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        wb_pc  = mk(4'd8, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
        br     = mk(4'd9, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 1, 0, 0);

        bus.Op = 2'b00; bus.Funct = 6'b0; bus.Rd = 4'd0;

        cyc("reset0", 1'b1, 2'b00, 6'b0, 4'd0, z);
        cyc("reset1", 1'b1, 2'b00, 6'b0, 4'd0, z);

        instr("add_r1", 2'b00, 6'b001000, 4'd1, '{fe, de,
              mk(4'd6, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0), wb});
        instr("subs_imm", 2'b00, 6'b100101, 4'd2, '{fe, de,
              mk(4'd7, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 0, 0, 0), wb});
        instr("ands_imm", 2'b00, 6'b100001, 4'd3, '{fe, de,
              mk(4'd7, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b10, 2'b10, 0, 0, 0), wb});
        instr("orrs_reg", 2'b00, 6'b011001, 4'd4, '{fe, de,
              mk(4'd6, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 0, 0, 0), wb});
        instr("eors_unsup", 2'b00, 6'b000011, 4'd5, '{fe, de,
              mk(4'd6, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 0, 0, 0), wb});
`ifdef CMP_NOWRITE_EN
        instr("cmp", 2'b00, 6'b010101, 4'd15, '{fe, de,
              mk(4'd6, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 0, 0, 0),
              mk(4'd8, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0)});
`else
        instr("cmp", 2'b00, 6'b010101, 4'd15, '{fe, de,
              mk(4'd6, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 0, 0, 0), wb_pc});
`endif
        instr("ldr", 2'b01, 6'b011001, 4'd3, '{fe, de, ma, mr, mwb});
        instr("str", 2'b01, 6'b011000, 4'd3, '{fe, de, ma, mw});
        instr("branch", 2'b10, 6'b101000, 4'd0, '{fe, de, br});
        instr("add_pc", 2'b00, 6'b001000, 4'd15, '{fe, de,
              mk(4'd6, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0), wb_pc});
        instr("ldr_pc", 2'b01, 6'b011001, 4'd15, '{fe, de, ma, mr, mwb_pc});
        instr("undef", 2'b11, 6'b000000, 4'd0, '{fe, de});

        // reset lands in MEMWRITE: store must be suppressed
        instr("str_abort", 2'b01, 6'b011000, 4'd6, '{fe, de, ma});
        cyc("str_abort.rst", 1'b1, 2'b01, 6'b011000, 4'd6, z);
        cyc("post_rst.fetch", 1'b0, 2'b00, 6'b001000, 4'd1, fe);
        cyc("post_rst.decode", 1'b0, 2'b00, 6'b001000, 4'd1, de);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
